// File: rtl/clk_div_pkg.sv
// Shared timing constants for the 12 MHz board clock and helpers for the divider bank.
package clk_div_pkg;
   localparam int CLK_IN_HZ  = 12_000_000;
   localparam int DIV_2MHZ   = 6;
   localparam int DIV_1MHZ   = 12;
   localparam int DIV_48KHZ  = 250;
   localparam int DIV_60HZ   = 200_000;
   localparam int DIV_10HZ   = 1_200_000;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/clk_divider_bank_if.sv
// Divisor write bus of the divider bank, with per-channel pending status returned.
interface clk_divider_bank_if
   import clk_div_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 24
);
   localparam int CH_W = ch_w(NUM_CH);

   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [CNT_W-1:0]  wr_div;
   logic [NUM_CH-1:0] pending;

   modport master (output wr_en, wr_ch, wr_div, input pending);
   modport slave  (input wr_en, wr_ch, wr_div, output pending);
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, live/shadow divisor and registered square/tick outputs.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk12Mhz,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic [CNT_W-1:0] div_init,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);
   logic [CNT_W-1:0] cnt, div, shadow;
   logic [CNT_W-1:0] cnt_next, div_next;
   logic             wrap, apply;

   always_comb begin
      wrap     = (div != '0) && (cnt == div - CNT_W'(1));
      apply    = wrap && pending;
      cnt_next = wrap ? '0 : cnt + CNT_W'(1);
      div_next = apply ? shadow : div;
   end

   always_ff @(posedge clk12Mhz) begin
      if (rst) begin
         cnt     <= '0;
         div     <= div_init;
         shadow  <= '0;
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (sync) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         pending <= 1'b0;
         if (wr) begin
            div    <= wr_div;
            shadow <= wr_div;
         end else if (pending) begin
            div <= shadow;
         end
      end else begin
         if (div == '0) begin
            // Halted channel: nothing to wait for, take a new divisor straight away.
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            if (pending) begin
               div     <= shadow;
               pending <= 1'b0;
            end
         end else if (!en) begin
            tick <= 1'b0;
         end else begin
            cnt     <= cnt_next;
            tick    <= wrap;
            // Judge the first cycle of a new period against the divisor that will govern it.
            clk_out <= (div_next != '0) && (cnt_next >= (div_next >> 1));
            if (apply) begin
               div     <= shadow;
               pending <= 1'b0;
            end
         end
         // A write landing on the wrap cycle only arms the next wrap.
         if (wr) begin
            shadow  <= wr_div;
            pending <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/clk_divider_bank.sv
// N-channel programmable tick/clock generator: write decode, range check and channel array.
module clk_divider_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 24,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_10HZ), CNT_W'(DIV_2MHZ)}
) (
   input  logic                clk12Mhz,
   input  logic                rst,
   input  logic                en,
   input  logic                sync,
   clk_divider_bank_if.slave   wbus,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick
);
   localparam int CH_W  = ch_w(NUM_CH);
   localparam int CHK_W = CH_W + 1;

   logic              wr_ok;
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] pend;

   // Out-of-range selects are dropped here so no channel ever sees them.
   assign wr_ok        = wbus.wr_en && ({1'b0, wbus.wr_ch} < CHK_W'(NUM_CH));
   assign wbus.pending = pend;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_hit[i] = wr_ok && (wbus.wr_ch == CH_W'(i));

      clk_div_channel #(.CNT_W(CNT_W)) u_ch (
         .clk12Mhz (clk12Mhz),
         .rst      (rst),
         .en       (en),
         .sync     (sync),
         .wr       (wr_hit[i]),
         .wr_div   (wbus.wr_div),
         .div_init (DIV_INIT[i*CNT_W +: CNT_W]),
         .clk_out  (clk_out[i]),
         .tick     (tick[i]),
         .pending  (pend[i])
      );
   end
endmodule
